// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button inputs and conditioned outputs of the button conditioner.
interface button_conditioner_if;
  logic pause_btn_raw;
  logic change_btn_raw;
  logic pause;
  logic change_state;
  logic pause_press;
  logic change_press;
  modport master (output pause_btn_raw, change_btn_raw, input pause, change_state, pause_press, change_press);
  modport slave (input pause_btn_raw, change_btn_raw, output pause, change_state, pause_press, change_press);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce and edge-detect two buttons into pause level and stretched change request; `AUTO_RESUME_EN lets a change press clear pause.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STRETCH_CYCLES = 50000000,
  parameter bit ACTIVE_LEVEL = 1'b1
) (
  input logic clk,
  input logic rst,
  button_conditioner_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SW = $clog2(STRETCH_CYCLES) + 1;
  typedef enum logic [1:0] {RELEASED, CHK_PRESS, PRESSED, CHK_REL} state_t;
  logic [1:0] raw, press;
  logic [SW-1:0] sc;
  logic pause_q, cs;
  assign raw = {bus.change_btn_raw, bus.pause_btn_raw};
  genvar g;
  for (g = 0; g < 2; g++) begin : g_btn
    logic s1, s2, pressed, hit, pulse_n, press_q;
    logic [CW-1:0] cnt, cnt_n;
    state_t st, st_n;
    assign pressed = s2 == ACTIVE_LEVEL;
    assign hit = cnt == CW'(DEBOUNCE_CYCLES - 1);
    assign press[g] = press_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1 <= ~ACTIVE_LEVEL;
        s2 <= ~ACTIVE_LEVEL;
        st <= RELEASED;
        cnt <= '0;
        press_q <= 1'b0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        st <= st_n;
        cnt <= cnt_n;
        press_q <= pulse_n;
      end
    end
    // counter restarts on every transition, so it never wraps
    always_comb begin
      st_n = st;
      cnt_n = cnt;
      pulse_n = 1'b0;
      case (st)
        RELEASED: if (pressed) begin st_n = CHK_PRESS; cnt_n = CW'(1); end
        CHK_PRESS:
          if (!pressed) begin st_n = RELEASED; cnt_n = '0; end
          else if (hit) begin st_n = PRESSED; cnt_n = '0; pulse_n = 1'b1; end
          else cnt_n = cnt + 1'b1;
        PRESSED: if (!pressed) begin st_n = CHK_REL; cnt_n = CW'(1); end
        CHK_REL:
          if (pressed) begin st_n = PRESSED; cnt_n = '0; end
          else if (hit) begin st_n = RELEASED; cnt_n = '0; end
          else cnt_n = cnt + 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cs <= 1'b0;
      sc <= '0;
      pause_q <= 1'b0;
    end else begin
      if (!cs && press[1]) begin
        cs <= 1'b1;
        sc <= SW'(STRETCH_CYCLES - 1);
      end else if (cs) begin
        if (sc == '0) cs <= 1'b0;
        else sc <= sc - 1'b1;
      end
`ifdef AUTO_RESUME_EN
      pause_q <= (press[1] && !cs && pause_q) ? 1'b0 : pause_q ^ press[0];
`else
      pause_q <= pause_q ^ press[0];
`endif
    end
  end
  assign bus.pause = pause_q;
  assign bus.change_state = cs;
  assign bus.pause_press = press[0];
  assign bus.change_press = press[1];
endmodule
